sub_bytes_serial: RTL and testbench

//  Byte-serial AES SubBytes engine. Takes a 128-bit AES state over a valid/ready

---
 rtl/sub_bytes_serial.sv | 77 +++++++
 tb/tb_sub_bytes_serial.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_serial.sv
// sub_bytes_serial: byte-serial AES SubBytes through one external S-box (SBOX_LAT 0 or 1).
// Define SUBBYTES_SHIFTROWS_EN to fuse ShiftRows into the write-back addressing.
module sub_bytes_serial #(
    parameter int SBOX_LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic [7:0]   sbox_in,
    input  logic [7:0]   sbox_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam bit REG = (SBOX_LAT == 1);

    state_t       state, state_nx;
    logic [127:0] src;
    logic [3:0]   rd_idx, wr_idx, wr_idx_q, dst;
    logic         tail, wr_en_q, wr_en, last, accept;

    always_comb begin
        state_nx  = state;
        in_ready  = (state == IDLE) || (state == DONE && out_ready);
        accept    = in_valid && in_ready;
        out_valid = state == DONE;
        busy      = state == RUN;
        wr_idx    = REG ? wr_idx_q : rd_idx;
        wr_en     = (state == RUN) && (REG ? wr_en_q : 1'b1);
        last      = REG ? tail : rd_idx == 4'd15;
        sbox_in   = (state == RUN) ? src[{~rd_idx, 3'b000} +: 8] : 8'd0;
        if (accept)
            state_nx = RUN;
        else if (state == RUN && last)
            state_nx = DONE;
        else if (state == DONE && out_ready)
            state_nx = IDLE;
    end

`ifdef SUBBYTES_SHIFTROWS_EN
    // byte at column c, row r lands in column (c - r) mod 4, same row
    assign dst = {wr_idx[3:2] - wr_idx[1:0], wr_idx[1:0]};
`else
    assign dst = wr_idx;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            src       <= '0;
            rd_idx    <= '0;
            wr_idx_q  <= '0;
            wr_en_q   <= 1'b0;
            tail      <= 1'b0;
            out_state <= '0;
        end else begin
            state    <= state_nx;
            wr_idx_q <= rd_idx;
            wr_en_q  <= (state == RUN) && !tail;
            if (accept) begin
                src    <= in_state;
                rd_idx <= '0;
                tail   <= 1'b0;
            end else if (state == RUN) begin
                // read index parks on byte 15 while a registered S-box drains
                rd_idx <= (rd_idx == 4'd15) ? rd_idx : rd_idx + 4'd1;
                tail   <= rd_idx == 4'd15;
            end
            if (wr_en)
                out_state[{~dst, 3'b000} +: 8] <= sbox_out;
        end
    end
endmodule

// File: tb/tb_sub_bytes_serial.sv
// tb_sub_bytes_serial: drives a combinational-S-box and a registered-S-box instance in lockstep,
// checking results against a GF(2^8) S-box model via a scoreboard and a fixed vector table.
module tb_sub_bytes_serial;
    logic         clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [127:0] in_state = '0;
    logic         in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
    logic [7:0]   sbox_in0, sbox_in1, sbox_out0, sbox_out1;
    logic [127:0] out_state0, out_state1;
    int tests = 0, fails = 0;
    logic [127:0] q0[$], q1[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00, x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] o = '0;
        for (int i = 0; i < 16; i++) begin
            int c = i / 4, r = i % 4, d;
`ifdef SUBBYTES_SHIFTROWS_EN
            d = 4 * ((c - r + 4) % 4) + r;
`else
            d = i;
`endif
            o[127 - 8 * d -: 8] = sbox_f(s[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    assign sbox_out0 = sbox_f(sbox_in0);
    always @(posedge clk) sbox_out1 <= sbox_f(sbox_in1);

    sub_bytes_serial #(.SBOX_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_state(in_state),
        .sbox_in(sbox_in0), .sbox_out(sbox_out0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_state(out_state0), .busy(busy0));
    sub_bytes_serial #(.SBOX_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_state(in_state),
        .sbox_in(sbox_in1), .sbox_out(sbox_out1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_state(out_state1), .busy(busy1));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (in_valid && in_ready0) q0.push_back(model(in_state));
            if (in_valid && in_ready1) q1.push_back(model(in_state));
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL sb0_extra: unexpected result %h", out_state0);
                end else chk("sb0_result", out_state0, q0.pop_front());
            end
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL sb1_extra: unexpected result %h", out_state1);
                end else chk("sb1_result", out_state1, q1.pop_front());
            end
        end
    end

    task automatic wait_done(input bit chk_lat);
        int lat0 = -1, lat1 = -1;
        for (int k = 1; k <= 40 && lat1 < 0; k++) begin
            @(posedge clk); #1;
            if (out_valid0 && lat0 < 0) lat0 = k;
            if (out_valid1 && lat1 < 0) lat1 = k;
        end
        if (chk_lat) begin
            chk("lat0", 128'(lat0), 128'd16);
            chk("lat1", 128'(lat1), 128'd17);
        end else if (lat1 < 0) chk("done_timeout", 128'(lat1), 128'd1);
    endtask

    task automatic send(input logic [127:0] v);
        in_valid = 1; in_state = v;
        @(posedge clk); #1;
        in_valid = 0; in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
        chk("busy_after_accept", {busy0, busy1}, 2'b11);
        wait_done(1);
    endtask

    task automatic drain();
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("idle_after_drain", {out_valid0, out_valid1, in_ready0, in_ready1}, 4'b0011);
    endtask

    typedef struct { logic [127:0] in; logic [127:0] exp; } vec_t;
    vec_t tbl[3];
    localparam logic [127:0] V2 = 128'h00112233445566778899aabbccddeeff;
`ifdef SUBBYTES_SHIFTROWS_EN
    localparam logic [127:0] E2 = 128'h63fcac161bee28c3c4c193f54b8233ea;
`else
    localparam logic [127:0] E2 = 128'h638293c31bfc33f5c4eeacea4bc12816;
`endif

    initial begin
        tbl[0] = '{128'h0, {16{8'h63}}};
        tbl[1] = '{V2, E2};
        tbl[2] = '{{16{8'hff}}, {16{8'h16}}};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out0", {out_valid0, in_ready0, busy0, sbox_in0, out_state0}, {3'b010, 8'h00, 128'h0});
        chk("reset_out1", {out_valid1, in_ready1, busy1, sbox_in1, out_state1}, {3'b010, 8'h00, 128'h0});
        rst = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            send(tbl[i].in);
            chk($sformatf("tbl%0d_lat0", i), out_state0, tbl[i].exp);
            chk($sformatf("tbl%0d_lat1", i), out_state1, tbl[i].exp);
            drain();
        end
        for (int i = 0; i < 3; i++) begin
            logic [127:0] v = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(v);
            chk("rand_out0", out_state0, model(v));
            drain();
        end
        // stall in DONE, then back-to-back accept
        send(128'h0123456789abcdeffedcba9876543210);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_hold", out_state0, model(128'h0123456789abcdeffedcba9876543210));
            chk("stall_ready", {in_ready0, in_ready1, out_valid0}, 3'b001);
        end
        out_ready = 1; in_valid = 1; in_state = V2;
        @(posedge clk); #1;
        out_ready = 0; in_valid = 0;
        chk("b2b_busy", {busy0, busy1}, 2'b11);
        wait_done(0);
        chk("b2b_result", out_state1, E2);
        drain();
        // reset while reading byte 7
        in_valid = 1; in_state = 128'hdeadbeef_cafef00d_01020304_a5a55a5a;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (7) @(posedge clk);
        #1 rst = 1;
        #1;
        chk("midrun_rst0", {out_valid0, in_ready0, busy0, out_state0}, {3'b010, 128'h0});
        chk("midrun_rst1", {out_valid1, in_ready1, busy1, out_state1}, {3'b010, 128'h0});
        @(posedge clk); #1 rst = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("no_pulse_after_rst", {out_valid0, out_valid1}, 2'b00);
        send(V2);
        chk("post_rst_out0", out_state0, E2);
        chk("post_rst_out1", out_state1, E2);
        drain();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
